// File: rtl/argmax_8_16.sv
// Streaming argmax: scans M signed elements per vector and emits the index and value of the maximum.
// The result register is double-buffered against the scan so the next vector is collected while a result waits.
module argmax_8_16 #(
    parameter  int unsigned M    = 8,
    parameter  int unsigned T    = 16,
    localparam int unsigned IDXW = $clog2(M)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            input_valid,
    output logic            input_ready,
    input  logic [T-1:0]    input_data,
    output logic            output_valid,
    input  logic            output_ready,
    output logic [IDXW-1:0] output_index,
    output logic [T-1:0]    output_value
);

    logic [IDXW-1:0]       cnt_q, cnt_d;
    logic signed [T-1:0]   best_val_q, best_val_d;
    logic [IDXW-1:0]       best_idx_q, best_idx_d;
    logic                  out_valid_q, out_valid_d;
    logic [IDXW-1:0]       out_idx_q, out_idx_d;
    logic signed [T-1:0]   out_val_q, out_val_d;

    logic                  last_c;
    logic                  in_acc_c;
    logic                  out_acc_c;
    logic                  take_c;
    logic signed [T-1:0]   data_s_c;

    // Only the last element can stall, and only behind an unconsumed result.
    assign last_c      = (cnt_q == IDXW'(M - 1));
    assign input_ready = ~(last_c & out_valid_q & ~output_ready);
    assign in_acc_c    = input_valid & input_ready;
    assign out_acc_c   = out_valid_q & output_ready;
    assign data_s_c    = $signed(input_data);
    // Strict compare keeps the lower index on ties.
    assign take_c      = (cnt_q == '0) || (data_s_c > best_val_q);

    always_comb begin
        cnt_d       = cnt_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_val_d   = out_val_q;

        if (in_acc_c) begin
            cnt_d = last_c ? '0 : cnt_q + IDXW'(1);
            if (take_c) begin
                best_val_d = data_s_c;
                best_idx_d = cnt_q;
            end
        end

        // A load wins over a simultaneous consume, so back-to-back results leave no bubble.
        if (in_acc_c && last_c) begin
            out_valid_d = 1'b1;
            out_idx_d   = take_c ? cnt_q    : best_idx_q;
            out_val_d   = take_c ? data_s_c : best_val_q;
        end else if (out_acc_c) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_val_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_val_q   <= out_val_d;
        end
    end

    assign output_valid = out_valid_q;
    assign output_index = out_idx_q;
    assign output_value = out_val_q;

endmodule

// File: tb/tb_argmax_8_16.sv
// Bench for argmax_8_16: directed vectors, back-pressure, throughput, mid-vector reset and
// randomized handshakes, checked against a max-then-first-index reference model.
module tb_argmax_8_16;

    typedef logic [15:0] vec_t [8];

    logic        clk = 1'b0;
    logic        reset;
    logic        input_valid;
    logic        input_ready;
    logic [15:0] input_data;
    logic        output_valid;
    logic        output_ready;
    logic [2:0]  output_index;
    logic [15:0] output_value;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_in   = 0;
    int ir_low   = 0;
    int rd       = 0;
    logic [2:0]  obs_idx [$];
    logic [15:0] obs_val [$];
    int          obs_cyc [$];

    always #5 clk = ~clk;

    argmax_8_16 dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_index (output_index),
        .output_value (output_value)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake monitor, sampled mid-cycle where all inputs and outputs are settled.
    always @(negedge clk) begin
        if (reset) begin
            if (input_valid && input_ready) acc_in = acc_in + 1;
            if (!input_ready) ir_low = ir_low + 1;
            if (output_valid && output_ready) begin
                obs_idx.push_back(output_index);
                obs_val.push_back(output_value);
                obs_cyc.push_back(cyc);
            end
        end
    end

    // Reference: find the maximum value first, then the lowest position holding it.
    function automatic void ref_max(input vec_t v, output logic [2:0] idx, output logic [15:0] val);
        int mx;
        mx  = -32768;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) if ($signed(v[i]) > mx) mx = $signed(v[i]);
        for (int i = 7; i >= 0; i--) if ($signed(v[i]) == mx) idx = 3'(i);
        val = 16'(mx);
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i] = 16'($urandom_range(0, 3));
                1:       v[i] = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
                default: v[i] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic send_elem(input logic [15:0] d, input int gap);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        input_valid = 1'b1;
        input_data  = d;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = input_ready;
            @(posedge clk);
            #1;
            n++;
        end
        input_valid = 1'b0;
        input_data  = 16'($urandom);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: input_ready=0 for %0d cycles, required acceptance", n);
        end
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_vec(input vec_t v, input int max_gap);
        for (int i = 0; i < 8; i++) send_elem(v[i], $urandom_range(0, max_gap));
    endtask

    task automatic wait_results(input int n, output bit ok);
        int k;
        k = 0;
        while (obs_idx.size() < rd + n && k < 4000) begin
            @(posedge clk);
            #1;
            k++;
        end
        ok = (obs_idx.size() >= rd + n);
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        input_valid  = 1'b0;
        input_data   = 16'($urandom);
        output_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (output_valid !== 1'b0 || output_index !== 3'd0 || output_value !== 16'd0 || input_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: got v=%b i=%0d val=%h rdy=%b, required v=0 i=0 val=0000 rdy=1",
                     output_valid, output_index, output_value, input_ready);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        vec_t        v [4];
        logic [2:0]  ei [4];
        logic [15:0] ev [4];
        bit          ok;
        v[0] = '{16'd3, 16'hFFFF, 16'd7, 16'd2, 16'd7, 16'd0, 16'hFFFB, 16'd1};
        v[1] = '{16'hFFF8, 16'hFFFD, 16'hFFF7, 16'hFFFD, 16'hFF9C, 16'hFFFC, 16'h8000, 16'hFFF9};
        v[2] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF};
        v[3] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        ei = '{3'd2, 3'd1, 3'd7, 3'd0};
        ev = '{16'h0007, 16'hFFFD, 16'h7FFF, 16'h7FFF};
        output_ready = 1'b1;
        for (int k = 0; k < 4; k++) send_vec(v[k], 0);
        wait_results(4, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL directed_count: got %0d results, required 4", obs_idx.size() - rd);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs_idx[rd] !== ei[k] || obs_val[rd] !== ev[k]) begin
                    failures++;
                    $display("FAIL directed_%0d: got idx=%0d val=%h, required idx=%0d val=%h",
                             k, obs_idx[rd], obs_val[rd], ei[k], ev[k]);
                end
                rd++;
            end
        end
    endtask

    task automatic test_backpressure();
        vec_t        v [3];
        logic [2:0]  ei [3];
        logic [15:0] ev [3];
        logic [2:0]  hi;
        logic [15:0] hv;
        bit          held_set, held_ok, stall_seen, stall_ok, ok;
        int          base;
        for (int k = 0; k < 3; k++) begin
            v[k] = rand_vec();
            ref_max(v[k], ei[k], ev[k]);
        end
        output_ready = 1'b0;
        base       = acc_in;
        held_set   = 1'b0;
        held_ok    = 1'b1;
        stall_seen = 1'b0;
        stall_ok   = 1'b1;
        hi         = 3'd0;
        hv         = 16'd0;
        fork
            for (int k = 0; k < 3; k++) send_vec(v[k], 0);
            begin
                repeat (40) begin
                    @(negedge clk);
                    if (!input_ready) begin
                        stall_seen = 1'b1;
                        if (acc_in - base != 15) stall_ok = 1'b0;
                    end
                    if (output_valid) begin
                        if (!held_set) begin
                            hi = output_index;
                            hv = output_value;
                            held_set = 1'b1;
                        end else if (output_index !== hi || output_value !== hv) begin
                            held_ok = 1'b0;
                        end
                    end
                end
                @(posedge clk);
                #1;
                output_ready = 1'b1;
            end
        join
        checks++;
        if (!stall_seen || !stall_ok) begin
            failures++;
            $display("FAIL bp_stall_point: seen=%b only_at_15=%b, required seen=1 only_at_15=1", stall_seen, stall_ok);
        end
        checks++;
        if (!held_set || !held_ok || hi !== ei[0] || hv !== ev[0]) begin
            failures++;
            $display("FAIL bp_hold: set=%b stable=%b idx=%0d val=%h, required 1 1 idx=%0d val=%h",
                     held_set, held_ok, hi, hv, ei[0], ev[0]);
        end
        wait_results(3, ok);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (obs_idx.size() - rd != 3) begin
            failures++;
            $display("FAIL bp_count: got %0d results, required 3", obs_idx.size() - rd);
        end
        if (ok) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_idx[rd] !== ei[k] || obs_val[rd] !== ev[k]) begin
                    failures++;
                    $display("FAIL bp_result_%0d: got idx=%0d val=%h, required idx=%0d val=%h",
                             k, obs_idx[rd], obs_val[rd], ei[k], ev[k]);
                end
                rd++;
            end
        end
        rd = obs_idx.size();
    endtask

    task automatic test_throughput();
        vec_t        v [100];
        logic [2:0]  ei [100];
        logic [15:0] ev [100];
        int          low0, bad_gap, bad_val, first;
        bit          ok;
        for (int k = 0; k < 100; k++) begin
            v[k] = rand_vec();
            ref_max(v[k], ei[k], ev[k]);
        end
        output_ready = 1'b1;
        low0  = ir_low;
        first = rd;
        for (int k = 0; k < 100; k++) send_vec(v[k], 0);
        wait_results(100, ok);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (obs_idx.size() - first != 100) begin
            failures++;
            $display("FAIL tput_count: got %0d results, required 100", obs_idx.size() - first);
        end
        checks++;
        if (ir_low != low0) begin
            failures++;
            $display("FAIL tput_ready: input_ready low %0d cycles, required 0", ir_low - low0);
        end
        if (ok) begin
            bad_gap = 0;
            bad_val = 0;
            for (int k = 0; k < 100; k++) begin
                if (k > 0 && obs_cyc[rd] - obs_cyc[rd-1] != 8) bad_gap++;
                if (obs_idx[rd] !== ei[k] || obs_val[rd] !== ev[k]) begin
                    bad_val++;
                    if (bad_val <= 5)
                        $display("FAIL tput_result_%0d: got idx=%0d val=%h, required idx=%0d val=%h",
                                 k, obs_idx[rd], obs_val[rd], ei[k], ev[k]);
                end
                rd++;
            end
            checks++;
            if (bad_val != 0) failures++;
            checks++;
            if (bad_gap != 0) begin
                failures++;
                $display("FAIL tput_spacing: %0d result gaps differ from 8 cycles, required 0", bad_gap);
            end
        end
        rd = obs_idx.size();
    endtask

    task automatic test_reset_mid();
        vec_t v0, v1;
        bit   ok;
        v0 = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'hFFFF};
        v1 = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        output_ready = 1'b0;
        send_vec(v0, 0);
        for (int i = 0; i < 5; i++) send_elem(16'h7FFF, 0);
        checks++;
        if (output_valid !== 1'b1 || output_index !== 3'd6 || output_value !== 16'd70) begin
            failures++;
            $display("FAIL rst_mid_pending: got v=%b i=%0d val=%h, required v=1 i=6 val=0046",
                     output_valid, output_index, output_value);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (output_valid !== 1'b0 || output_index !== 3'd0 || output_value !== 16'd0 || input_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_clear: got v=%b i=%0d val=%h rdy=%b, required 0 0 0000 1",
                     output_valid, output_index, output_value, input_ready);
        end
        @(posedge clk);
        #1;
        reset        = 1'b1;
        output_ready = 1'b1;
        rd           = obs_idx.size();
        send_vec(v1, 0);
        wait_results(1, ok);
        checks++;
        if (!ok || obs_idx[rd] !== 3'd7 || obs_val[rd] !== 16'd8) begin
            failures++;
            if (ok)
                $display("FAIL rst_mid_next: got idx=%0d val=%h, required idx=7 val=0008", obs_idx[rd], obs_val[rd]);
            else
                $display("FAIL rst_mid_next: no result, required idx=7 val=0008");
        end
        rd = obs_idx.size();
    endtask

    task automatic test_random();
        vec_t        v [30];
        logic [2:0]  ei [30];
        logic [15:0] ev [30];
        bit          done, ok;
        int          bad;
        for (int k = 0; k < 30; k++) begin
            v[k] = rand_vec();
            ref_max(v[k], ei[k], ev[k]);
        end
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 30; k++) send_vec(v[k], 2);
                done = 1'b1;
            end
            while (!done) begin
                @(posedge clk);
                #1;
                output_ready = ($urandom_range(0, 2) != 0);
            end
        join
        output_ready = 1'b1;
        wait_results(30, ok);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (obs_idx.size() - rd != 30) begin
            failures++;
            $display("FAIL rand_count: got %0d results, required 30", obs_idx.size() - rd);
        end
        if (ok) begin
            bad = 0;
            for (int k = 0; k < 30; k++) begin
                if (obs_idx[rd] !== ei[k] || obs_val[rd] !== ev[k]) begin
                    bad++;
                    if (bad <= 5)
                        $display("FAIL rand_result_%0d: got idx=%0d val=%h, required idx=%0d val=%h",
                                 k, obs_idx[rd], obs_val[rd], ei[k], ev[k]);
                end
                rd++;
            end
            checks++;
            if (bad != 0) failures++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_throughput();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
